gmii_frame_tx: RTL and testbench

- MAC-side GMII transmit framer: turns a byte stream with valid/ready/last into a complete Ethernet frame on gmii_tx_en/gmii_txd.
- Adds 7x preamble, SFD, zero padding to MIN_LEN, CRC-32 FCS, and enforces inter-frame gap.
- Output feeds the GMII transmit port of the RGMII adapter; runs in that adapter's transmit clock domain.
- 1000M byte-per-cycle operation only. 10/100M nibble pacing is outside this block.

---
 rtl/gmii_frame_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_gmii_frame_tx.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_frame_tx.sv
// gmii_frame_tx: MAC-side GMII transmit framer for 1000M byte-per-cycle operation.
// Wraps a valid/ready/last byte stream with preamble, SFD, zero padding up to
// MIN_LEN, an Ethernet CRC-32 FCS and an enforced inter-frame gap. Underruns and
// oversize frames are terminated with a deliberately wrong FCS so the link
// partner discards them.
module gmii_frame_tx #(
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514,
    parameter int IFG_CYCLES = 12
) (
    input  logic       gmii_tx_clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       err_underrun,
    output logic       err_oversize
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam int          IFG_W     = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DROP,
        ST_IFG
    } state_t;

    // Reflected Ethernet CRC-32 (poly 0x04C11DB7 reversed), one byte LSB-first.
    function automatic logic [31:0] crc32_upd(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // FCS byte idx (LSB first); a corrupt frame sends the raw register so the
    // receiver's check can never match.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx,
                                            input logic corrupt);
        logic [31:0] v;
        logic [7:0]  b;
        v = corrupt ? crc : ~crc;
        case (idx)
            2'd0:    b = v[7:0];
            2'd1:    b = v[15:8];
            2'd2:    b = v[23:16];
            2'd3:    b = v[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t           r_state;
    logic [31:0]      r_crc;
    logic [15:0]      r_cnt;
    logic [2:0]       r_pre_cnt;
    logic [1:0]       r_fcs_idx;
    logic             r_corrupt;
    logic             r_oversize;
    logic [IFG_W-1:0] r_ifg_cnt;
    logic             r_tx_en;
    logic [7:0]       r_txd;
    logic             r_done;
    logic             r_err_underrun;
    logic             r_err_oversize;

    logic [31:0] w_crc_data;
    logic [31:0] w_crc_pad;
    logic [15:0] w_cnt_inc;

    assign w_crc_data = crc32_upd(r_crc, in_data);
    assign w_crc_pad  = crc32_upd(r_crc, 8'h00);
    assign w_cnt_inc  = r_cnt + 16'd1;

    // Frame sequencer: state, CRC, byte counters and every registered output
    always_ff @(posedge gmii_tx_clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_crc          <= 32'hFFFF_FFFF;
            r_cnt          <= 16'd0;
            r_pre_cnt      <= 3'd0;
            r_fcs_idx      <= 2'd0;
            r_corrupt      <= 1'b0;
            r_oversize     <= 1'b0;
            r_ifg_cnt      <= '0;
            r_tx_en        <= 1'b0;
            r_txd          <= 8'h00;
            r_done         <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_oversize <= 1'b0;
        end else begin
            r_done         <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_oversize <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state    <= ST_PRE;
                        r_crc      <= 32'hFFFF_FFFF;
                        r_cnt      <= 16'd0;
                        r_pre_cnt  <= 3'd1;
                        r_corrupt  <= 1'b0;
                        r_oversize <= 1'b0;
                        r_tx_en    <= 1'b1;
                        r_txd      <= 8'h55;
                    end else begin
                        r_tx_en <= 1'b0;
                        r_txd   <= 8'h00;
                    end
                end
                ST_PRE: begin
                    // First preamble byte was issued on leaving IDLE; six more here.
                    r_tx_en   <= 1'b1;
                    r_txd     <= 8'h55;
                    r_pre_cnt <= r_pre_cnt + 3'd1;
                    if (r_pre_cnt == 3'd6) begin
                        r_state <= ST_SFD;
                    end else begin
                        r_state <= ST_PRE;
                    end
                end
                ST_SFD: begin
                    r_tx_en <= 1'b1;
                    r_txd   <= 8'hD5;
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    r_tx_en <= 1'b1;
                    if (in_valid) begin
                        r_txd <= in_data;
                        r_crc <= w_crc_data;
                        r_cnt <= w_cnt_inc;
                        if (in_last) begin
                            r_fcs_idx <= 2'd0;
                            r_state   <= (w_cnt_inc < MIN_LEN_W) ? ST_PAD : ST_FCS;
                        end else if (w_cnt_inc == MAX_LEN_W) begin
                            r_err_oversize <= 1'b1;
                            r_corrupt      <= 1'b1;
                            r_oversize     <= 1'b1;
                            r_fcs_idx      <= 2'd0;
                            r_state        <= ST_FCS;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        // Underrun: no data byte this cycle, FCS byte 0 follows directly.
                        r_err_underrun <= 1'b1;
                        r_corrupt      <= 1'b1;
                        r_txd          <= fcs_byte(r_crc, 2'd0, 1'b1);
                        r_fcs_idx      <= 2'd1;
                        r_state        <= ST_FCS;
                    end
                end
                ST_PAD: begin
                    r_tx_en <= 1'b1;
                    r_txd   <= 8'h00;
                    r_crc   <= w_crc_pad;
                    r_cnt   <= w_cnt_inc;
                    if (w_cnt_inc >= MIN_LEN_W) begin
                        r_fcs_idx <= 2'd0;
                        r_state   <= ST_FCS;
                    end else begin
                        r_state <= ST_PAD;
                    end
                end
                ST_FCS: begin
                    r_tx_en   <= 1'b1;
                    r_txd     <= fcs_byte(r_crc, r_fcs_idx, r_corrupt);
                    r_fcs_idx <= r_fcs_idx + 2'd1;
                    if (r_fcs_idx == 2'd3) begin
                        r_done    <= ~r_corrupt;
                        r_ifg_cnt <= '0;
                        r_state   <= r_oversize ? ST_DROP : ST_IFG;
                    end else begin
                        r_state <= ST_FCS;
                    end
                end
                ST_DROP: begin
                    // Swallow the rest of an oversize frame; the gap starts afterwards.
                    r_tx_en <= 1'b0;
                    r_txd   <= 8'h00;
                    if (in_valid && in_last) begin
                        r_ifg_cnt <= '0;
                        r_state   <= ST_IFG;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end
                ST_IFG: begin
                    r_tx_en <= 1'b0;
                    r_txd   <= 8'h00;
                    if (r_ifg_cnt == IFG_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + IFG_W'(1);
                        r_state   <= ST_IFG;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx_en <= 1'b0;
                    r_txd   <= 8'h00;
                end
            endcase
        end
    end

    assign in_ready     = (r_state == ST_DATA) || (r_state == ST_DROP);
    assign tx_busy      = (r_state != ST_IDLE);
    assign gmii_tx_en   = r_tx_en;
    assign gmii_txd     = r_txd;
    assign frame_done   = r_done;
    assign err_underrun = r_err_underrun;
    assign err_oversize = r_err_oversize;

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for gmii_frame_tx. Two instances: dut_s (MIN_LEN=9, MAX_LEN=64)
// and dut_d (defaults); sel routes the shared stimulus to one of them and the
// observed outputs back. A negedge monitor records one entry per cycle.
module tb_gmii_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       sel;

    logic       rdy_s, en_s, busy_s, done_s, eu_s, eo_s;
    logic [7:0] txd_s;
    logic       rdy_d, en_d, busy_d, done_d, eu_d, eo_d;
    logic [7:0] txd_d;
    logic       vld_s, vld_d;

    logic       w_ready, w_en, w_busy, w_done, w_eu, w_eo;
    logic [7:0] w_txd;

    assign vld_s   = in_valid & ~sel;
    assign vld_d   = in_valid & sel;
    assign w_ready = sel ? rdy_d  : rdy_s;
    assign w_en    = sel ? en_d   : en_s;
    assign w_txd   = sel ? txd_d  : txd_s;
    assign w_busy  = sel ? busy_d : busy_s;
    assign w_done  = sel ? done_d : done_s;
    assign w_eu    = sel ? eu_d   : eu_s;
    assign w_eo    = sel ? eo_d   : eo_s;

    gmii_frame_tx #(.MIN_LEN(9), .MAX_LEN(64), .IFG_CYCLES(12)) dut_s (
        .gmii_tx_clk (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (vld_s),
        .in_last     (in_last),
        .in_ready    (rdy_s),
        .gmii_tx_en  (en_s),
        .gmii_txd    (txd_s),
        .tx_busy     (busy_s),
        .frame_done  (done_s),
        .err_underrun(eu_s),
        .err_oversize(eo_s)
    );

    gmii_frame_tx dut_d (
        .gmii_tx_clk (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (vld_d),
        .in_last     (in_last),
        .in_ready    (rdy_d),
        .gmii_tx_en  (en_d),
        .gmii_txd    (txd_d),
        .tx_busy     (busy_d),
        .frame_done  (done_d),
        .err_underrun(eu_d),
        .err_oversize(eo_d)
    );

    // 125 MHz transmit clock
    initial clk = 1'b0;
    always #4 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [7:0] d;
        logic       done;
        logic       eu;
        logic       eo;
        logic       acc;
    } rec_t;

    rec_t       q[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;

    // Per-cycle recorder, sampled mid-cycle away from the active edge
    always @(negedge clk) begin
        q.push_back({w_en, w_txd, w_done, w_eu, w_eo, in_valid & w_ready});
    end

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until the DUT takes it (bounded)
    task automatic put(input logic [7:0] b, input logic last);
        bit ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        for (int g = 0; g < 200 && !ok; g++) begin
            @(negedge clk);
            if (w_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("handshake", 32'(ok), 32'd1);
    endtask

    function automatic rec_t get(input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return '0;
    endfunction

    function automatic int first_en(input int from);
        for (int i = (from < 0 ? 0 : from); i < q.size(); i++) begin
            if (q[i].en) return i;
        end
        return -1;
    endfunction

    function automatic int cnt_flag(input int which);
        int n = 0;
        foreach (q[i]) begin
            case (which)
                0: if (q[i].done) n++;
                1: if (q[i].eu)   n++;
                2: if (q[i].eo)   n++;
                3: if (q[i].en)   n++;
                4: if (q[i].acc)  n++;
                default: n = n;
            endcase
        end
        return n;
    endfunction

    // Bit-serial reference CRC register over the first n bytes of exp_q
    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ exp_q[k][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    // Check preamble, SFD, n payload bytes from exp_q, FCS, and tx_en dropping after
    task automatic check_frame(input string tag, input int from, input int n,
                               input bit corrupt, output int s);
        logic [31:0] f;
        logic [7:0]  e;
        rec_t        r;
        s = first_en(from);
        chk($sformatf("%s start_found", tag), 32'(s >= from), 32'd1);
        f = corrupt ? model_crc(n) : ~model_crc(n);
        for (int i = 0; i < n + 12; i++) begin
            if (i < 7)           e = 8'h55;
            else if (i == 7)     e = 8'hD5;
            else if (i < 8 + n)  e = exp_q[i-8];
            else                 e = 8'(f >> (8 * (i - 8 - n)));
            r = get(s + i);
            chk($sformatf("%s byte%0d", tag, i), {23'd0, r.en, r.d}, {23'd0, 1'b1, e});
        end
        r = get(s + n + 12);
        chk($sformatf("%s en_after", tag), 32'(r.en), 32'd0);
        r = get(s + n + 11);
        chk($sformatf("%s done_last", tag), 32'(r.done), 32'(!corrupt));
    endtask

    logic [7:0] v1 [0:20];
    logic [7:0] aq[$];
    logic [7:0] bq[$];
    logic [7:0] oq[$];

    initial begin
        int   s, s2, k, na;
        rec_t r;
        v1 = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
               8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; sel = 1'b0;
        step(3);

        // Reset state on both instances
        chk("rst_s en",   32'(w_en),   32'd0);
        chk("rst_s txd",  32'(w_txd),  32'd0);
        chk("rst_s busy", 32'(w_busy), 32'd0);
        sel = 1'b1; #1;
        chk("rst_d en",    32'(w_en),    32'd0);
        chk("rst_d ready", 32'(w_ready), 32'd0);
        rst_n = 1'b1;
        step(2);
        chk("idle busy",  32'(w_busy),  32'd0);
        chk("idle ready", 32'(w_ready), 32'd0);

        // T1: MIN_LEN=9, "123456789" -> known FCS 26 39 F4 CB
        sel = 1'b0; step(1); q.delete();
        for (int i = 0; i < 9; i++) put(8'(8'h31 + i), i == 8);
        in_valid = 1'b0; in_last = 1'b0;
        step(30);
        s = first_en(0);
        for (int i = 0; i < 21; i++) begin
            r = get(s + i);
            chk($sformatf("t1 byte%0d", i), {23'd0, r.en, r.d}, {23'd0, 1'b1, v1[i]});
        end
        r = get(s + 21);
        chk("t1 en_after", 32'(r.en), 32'd0);
        chk("t1 en_cycles", 32'(cnt_flag(3)), 32'd21);
        chk("t1 done_count", 32'(cnt_flag(0)), 32'd1);
        r = get(s + 20);
        chk("t1 done_on_cb", 32'(r.done), 32'd1);

        // T2: defaults, 14-byte frame padded to 60
        sel = 1'b1; step(1); q.delete(); exp_q.delete();
        for (int i = 0; i < 14; i++) exp_q.push_back(8'(8'h10 + i));
        for (int i = 0; i < 46; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 14; i++) put(exp_q[i], i == 13);
        in_valid = 1'b0; in_last = 1'b0;
        step(100);
        check_frame("t2", 0, 60, 1'b0, s);
        chk("t2 en_cycles", 32'(cnt_flag(3)), 32'd72);
        chk("t2 done_count", 32'(cnt_flag(0)), 32'd1);

        // T3: two 60-byte frames with in_valid held -> 12-cycle gap
        step(1); q.delete(); aq.delete(); bq.delete();
        for (int i = 0; i < 60; i++) aq.push_back(8'(i * 3 + 1));
        for (int i = 0; i < 60; i++) bq.push_back(8'(8'hFF - i));
        for (int i = 0; i < 60; i++) put(aq[i], i == 59);
        for (int i = 0; i < 60; i++) put(bq[i], i == 59);
        in_valid = 1'b0; in_last = 1'b0;
        step(100);
        exp_q = aq;
        check_frame("t3a", 0, 60, 1'b0, s);
        for (int g = 1; g <= 12; g++) begin
            r = get(s + 71 + g);
            chk($sformatf("t3 gap%0d", g), 32'(r.en), 32'd0);
        end
        chk("t3 next_start", 32'(first_en(s + 72)), 32'(s + 84));
        exp_q = bq;
        check_frame("t3b", s + 72, 60, 1'b0, s2);
        chk("t3 done_count", 32'(cnt_flag(0)), 32'd2);

        // T4: underrun after byte 20
        step(1); q.delete(); exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(8'(8'h80 ^ i));
        for (int i = 0; i < 20; i++) put(exp_q[i], 1'b0);
        in_valid = 1'b0; in_last = 1'b0;
        step(60);
        check_frame("t4", 0, 20, 1'b1, s);
        chk("t4 eu_count", 32'(cnt_flag(1)), 32'd1);
        r = get(s + 28);
        chk("t4 eu_pos", 32'(r.eu), 32'd1);
        chk("t4 done_count", 32'(cnt_flag(0)), 32'd0);
        chk("t4 eo_count", 32'(cnt_flag(2)), 32'd0);

        // T5: MAX_LEN=64, 100-byte frame then a normal frame right behind it
        sel = 1'b0; step(1); q.delete(); oq.delete(); exp_q.delete();
        for (int i = 0; i < 100; i++) oq.push_back(8'(i) ^ 8'h5A);
        for (int i = 0; i < 100; i++) put(oq[i], i == 99);
        for (int i = 0; i < 9; i++) put(8'(8'h31 + i), i == 8);
        in_valid = 1'b0; in_last = 1'b0;
        step(60);
        for (int i = 0; i < 64; i++) exp_q.push_back(oq[i]);
        check_frame("t5", 0, 64, 1'b1, s);
        chk("t5 eo_count", 32'(cnt_flag(2)), 32'd1);
        r = get(s + 71);
        chk("t5 eo_pos", 32'(r.eo), 32'd1);
        chk("t5 accepted", 32'(cnt_flag(4)), 32'd109);
        chk("t5 en_cycles", 32'(cnt_flag(3)), 32'd97);
        k = -1; na = 0;
        foreach (q[i]) begin
            if (q[i].acc) begin
                na++;
                if (na == 100) k = i;
            end
        end
        for (int g = 1; g <= 13; g++) begin
            r = get(k + g);
            chk($sformatf("t5 gap%0d", g), 32'(r.en), 32'd0);
        end
        chk("t5 next_start", 32'(first_en(s + 76)), 32'(k + 14));
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
        check_frame("t5b", s + 76, 9, 1'b0, s2);
        chk("t5 done_count", 32'(cnt_flag(0)), 32'd1);

        // T6: reset for one edge in the middle of DATA
        sel = 1'b1; step(1); q.delete();
        for (int i = 0; i < 10; i++) put(8'(8'hC0 + i), 1'b0);
        rst_n = 1'b0;
        step(1);
        chk("t6 rst_en",    32'(w_en),    32'd0);
        chk("t6 rst_txd",   32'(w_txd),   32'd0);
        chk("t6 rst_busy",  32'(w_busy),  32'd0);
        chk("t6 rst_ready", 32'(w_ready), 32'd0);
        chk("t6 rst_eu",    32'(w_eu),    32'd0);
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        step(5);
        chk("t6 no_fcs", 32'(cnt_flag(3)), 32'd18);
        q.delete(); exp_q.delete();
        for (int i = 0; i < 14; i++) exp_q.push_back(8'(8'hE0 + i));
        for (int i = 0; i < 46; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 14; i++) put(exp_q[i], i == 13);
        in_valid = 1'b0; in_last = 1'b0;
        step(100);
        check_frame("t6", 0, 60, 1'b0, s);
        chk("t6 done_count", 32'(cnt_flag(0)), 32'd1);
        chk("t6 eu_count",   32'(cnt_flag(1)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
